// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared defaults, MIPS register names and write-port priority
// helper for the multi-port register file.
`default_nettype none

package reg_file_pkg;

  localparam int REG_DATA_W = 32;
  localparam int REG_ADDR_W = 5;

  // Upper bound on write ports the priority helper can resolve.
  localparam int MAX_WR_PORTS = 8;

  localparam int ZERO = 0;
  localparam int S0   = 16;
  localparam int SP   = 29;
  localparam int RA   = 31;

  // Highest set bit wins: later write ports override earlier ones.
  function automatic int unsigned wr_winner(input logic [MAX_WR_PORTS-1:0] hits);
    int unsigned idx;
    idx = 0;
    for (int unsigned j = 0; j < MAX_WR_PORTS; j++) begin
      if (hits[j]) idx = j;
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if: read, write, issue and debug signals of the register file.
`default_nettype none

interface reg_file_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
);

  logic [NUM_RD*ADDR_W-1:0] ra;
  logic [NUM_RD*DATA_W-1:0] rd;
  logic [NUM_RD-1:0]        rd_busy;
  logic [NUM_WR-1:0]        we;
  logic [NUM_WR*ADDR_W-1:0] wa;
  logic [NUM_WR*DATA_W-1:0] wd;
  logic                     iss_valid;
  logic [ADDR_W-1:0]        iss_addr;
  logic [ADDR_W:0]          busy_cnt;
  logic [7:0]               leds;

  modport master (
    output ra, we, wa, wd, iss_valid, iss_addr,
    input  rd, rd_busy, busy_cnt, leds
  );

  modport slave (
    input  ra, we, wa, wd, iss_valid, iss_addr,
    output rd, rd_busy, busy_cnt, leds
  );

endinterface

`default_nettype wire

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register busy bits for in-flight long-latency writes,
// with a running count of busy registers.
`default_nettype none

module reg_scoreboard #(
  parameter int ADDR_W = 5
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  input  wire logic                 i_iss_valid,
  input  wire logic [ADDR_W-1:0]    i_iss_addr,
  input  wire logic [2**ADDR_W-1:0] i_wr_clr,
  output logic      [2**ADDR_W-1:0] o_busy,
  output logic      [ADDR_W:0]      o_busy_cnt
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] r_busy;
  logic [ADDR_W:0]  r_cnt;
  logic [DEPTH-1:0] w_set;
  logic [DEPTH-1:0] w_clr_hit;
  logic [DEPTH-1:0] w_busy_nxt;
  logic [ADDR_W:0]  w_inc;
  logic [ADDR_W:0]  w_dec;
  logic [ADDR_W:0]  w_cnt_nxt;

  always_comb begin
    w_set = '0;
    if (i_iss_valid && (i_iss_addr != '0)) w_set[i_iss_addr] = 1'b1;
  end

  // A same-edge issue keeps the bit set, so it is excluded from the clears.
  assign w_clr_hit  = r_busy & i_wr_clr & ~w_set;
  assign w_busy_nxt = (r_busy & ~i_wr_clr) | w_set;

  always_comb begin
    w_inc = '0;
    if (|(w_set & ~r_busy)) w_inc = {{ADDR_W{1'b0}}, 1'b1};
  end

  always_comb begin
    w_dec = '0;
    for (int a = 0; a < DEPTH; a++) begin
      w_dec = w_dec + {{ADDR_W{1'b0}}, w_clr_hit[a]};
    end
  end

  assign w_cnt_nxt = r_cnt + w_inc - w_dec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign o_busy     = r_busy;
  assign o_busy_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with write-through bypass, hardwired
// zero register, busy scoreboard and an LED tap on one register.
`default_nettype none

module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W  = REG_DATA_W,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int NUM_RD  = 2,
  parameter int NUM_WR  = 2,
  parameter int DBG_REG = S0
) (
  input wire logic     clk,
  input wire logic     rst_n,
  reg_file_mp_if.slave bus
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] r_rf [DEPTH];
  logic [DEPTH-1:0]  w_wr_clr;
  logic [DEPTH-1:0]  w_busy;

  // Any enabled write retires the pending op on its destination.
  always_comb begin
    w_wr_clr = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      if (bus.we[j]) w_wr_clr[bus.wa[j*ADDR_W +: ADDR_W]] = 1'b1;
    end
    w_wr_clr[0] = 1'b0;
  end

  // Ascending port order lets the highest enabled port land last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < DEPTH; a++) r_rf[a] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (bus.we[j] && (bus.wa[j*ADDR_W +: ADDR_W] != '0)) begin
          r_rf[bus.wa[j*ADDR_W +: ADDR_W]] <= bus.wd[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0]       w_ra;
    logic [MAX_WR_PORTS-1:0] w_hit;
    logic [DATA_W-1:0]       w_rd;

    assign w_ra = bus.ra[i*ADDR_W +: ADDR_W];

    always_comb begin
      w_hit = '0;
      for (int j = 0; j < NUM_WR; j++) begin
        w_hit[j] = bus.we[j] && (bus.wa[j*ADDR_W +: ADDR_W] == w_ra);
      end
    end

    always_comb begin
      w_rd = r_rf[w_ra];
      if (w_ra == '0) begin
        w_rd = '0;
      end else if (|w_hit) begin
        w_rd = bus.wd[wr_winner(w_hit)*DATA_W +: DATA_W];
      end
    end

    assign bus.rd[i*DATA_W +: DATA_W] = w_rd;
    assign bus.rd_busy[i]             = w_busy[w_ra];
  end

  reg_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_iss_valid (bus.iss_valid),
    .i_iss_addr  (bus.iss_addr),
    .i_wr_clr    (w_wr_clr),
    .o_busy      (w_busy),
    .o_busy_cnt  (bus.busy_cnt)
  );

  assign bus.leds = r_rf[DBG_REG][7:0];

endmodule

`default_nettype wire

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed and random stimulus against a behavioural register
// model; expected outputs are queued and compared by a separate monitor.
`default_nettype none

module tb_reg_file_mp;

  typedef struct {
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic [1:0]  rb;
    logic [5:0]  cnt;
    logic [7:0]  leds;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  exp_t exp_q[$];

  logic [31:0] m_rf   [32];
  bit          m_busy [32];

  reg_file_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) bus ();

  reg_file_mp #(
    .DATA_W (32), .ADDR_W (5), .NUM_RD (2), .NUM_WR (2), .DBG_REG (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("rd0", bus.rd[31:0], e.rd0);
      chk("rd1", bus.rd[63:32], e.rd1);
      chk("rd_busy", {30'd0, bus.rd_busy}, {30'd0, e.rb});
      chk("busy_cnt", {26'd0, bus.busy_cnt}, {26'd0, e.cnt});
      chk("leds", {24'd0, bus.leds}, {24'd0, e.leds});
    end
  end

  function automatic logic [31:0] model_rd(input logic [4:0] a, input logic [1:0] we,
                                           input logic [4:0] w0, input logic [4:0] w1,
                                           input logic [31:0] d0, input logic [31:0] d1);
    if (a == 5'd0) return 32'd0;
    if (we[1] && w1 == a) return d1;
    if (we[0] && w0 == a) return d0;
    return m_rf[a];
  endfunction

  function automatic logic [5:0] model_cnt();
    int c;
    c = 0;
    for (int a = 0; a < 32; a++) c += m_busy[a] ? 1 : 0;
    return 6'(c);
  endfunction

  task automatic model_reset();
    for (int a = 0; a < 32; a++) begin
      m_rf[a]   = 32'd0;
      m_busy[a] = 1'b0;
    end
  endtask

  task automatic step(input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] we,
                      input logic [4:0] w0, input logic [4:0] w1,
                      input logic [31:0] d0, input logic [31:0] d1,
                      input logic iv, input logic [4:0] ia);
    exp_t e;
    bus.ra = {a1, a0};
    bus.we = we;
    bus.wa = {w1, w0};
    bus.wd = {d1, d0};
    bus.iss_valid = iv;
    bus.iss_addr  = ia;
    e.rd0  = model_rd(a0, we, w0, w1, d0, d1);
    e.rd1  = model_rd(a1, we, w0, w1, d0, d1);
    e.rb   = {m_busy[a1], m_busy[a0]};
    e.cnt  = model_cnt();
    e.leds = m_rf[16][7:0];
    exp_q.push_back(e);
    @(posedge clk);
    if (rst_n) begin
      if (we[0] && w0 != 5'd0) m_rf[w0] = d0;
      if (we[1] && w1 != 5'd0) m_rf[w1] = d1;
      if (we[0]) m_busy[w0] = 1'b0;
      if (we[1]) m_busy[w1] = 1'b0;
      if (iv && ia != 5'd0) m_busy[ia] = 1'b1;
      m_busy[0] = 1'b0;
    end
    #2;
  endtask

  task automatic rd_only(input logic [4:0] a0, input logic [4:0] a1);
    step(a0, a1, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0);
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 5'd16;
    return 5'($urandom_range(0, 9));
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.ra = '0; bus.we = '0; bus.wa = '0; bus.wd = '0;
    bus.iss_valid = 1'b0; bus.iss_addr = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++) rd_only(5'(i), 5'(31 - i));

    // Bypass on same-cycle write, then registered value and LEDs.
    step(5'd16, 5'd0, 2'b01, 5'd16, 5'd0, 32'h0000_00A5, 32'd0, 1'b0, 5'd0);
    rd_only(5'd16, 5'd16);

    // Port priority and register-0 write drop.
    step(5'd8, 5'd8, 2'b11, 5'd8, 5'd8, 32'h1111_1111, 32'h2222_2222, 1'b0, 5'd0);
    rd_only(5'd8, 5'd0);
    step(5'd0, 5'd8, 2'b01, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd0);
    rd_only(5'd0, 5'd8);

    // Scoreboard set, re-issue and clear.
    step(5'd5, 5'd6, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd5);
    step(5'd5, 5'd6, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd6);
    step(5'd5, 5'd6, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd5);
    step(5'd5, 5'd6, 2'b01, 5'd5, 5'd0, 32'h5555_0005, 32'd0, 1'b0, 5'd0);
    rd_only(5'd5, 5'd6);

    // Issue and write on the same register in one cycle: set wins.
    step(5'd9, 5'd6, 2'b10, 5'd0, 5'd9, 32'd0, 32'h0909_0909, 1'b1, 5'd9);
    rd_only(5'd9, 5'd6);
    step(5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd0);
    step(5'd3, 5'd0, 2'b01, 5'd3, 5'd0, 32'h3333_3333, 32'd0, 1'b1, 5'd3);
    rd_only(5'd3, 5'd9);

    for (int n = 0; n < 300; n++) begin
      step(rnd_addr(), rnd_addr(), 2'($urandom_range(0, 3)), rnd_addr(), rnd_addr(),
           $urandom, $urandom, 1'($urandom_range(0, 1)), rnd_addr());
    end

    // Reset mid-cycle while a write to register 3 is presented.
    rd_only(5'd3, 5'd16);
    bus.ra = {5'd16, 5'd3};
    bus.we = 2'b01; bus.wa = {5'd0, 5'd3}; bus.wd = {32'd0, 32'hDEAD_BEEF};
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd7;
    rst_n = 1'b0;
    model_reset();
    begin
      exp_t e;
      e.rd0 = 32'hDEAD_BEEF; e.rd1 = 32'd0; e.rb = 2'b00; e.cnt = 6'd0; e.leds = 8'd0;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    rd_only(5'd3, 5'd7);
    step(5'd7, 5'd3, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd7);
    rd_only(5'd7, 5'd3);

    begin
      int waited;
      waited = 0;
      while (exp_q.size() > 0 && waited < 10) begin
        @(posedge clk);
        waited++;
      end
      if (exp_q.size() > 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
